// File: rtl/mult_pkg.sv
// Shared types and constants for the byte-serial multiplier front end.
package mult_pkg;

    typedef enum logic [1:0] {LOAD, ARM, RUN, SEND} fe_state_t;

    localparam int OP_W       = 16;
    localparam int RES_W      = 32;
    localparam int NBYTES_OP  = 4;
    localparam int NBYTES_RES = 4;
    localparam int BYTE_W     = 8;

    localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

    // Little-endian byte select out of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mult_byte_frontend_if.sv
// Byte write stream, byte read stream and error flag of the multiplier front end.
interface mult_byte_frontend_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       err;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, err
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, err
    );

endinterface

// File: rtl/mult_byte_frontend.sv
// Packs four write bytes into two operands, runs the shift-add multiplier with a
// timeout guard, and streams the 32-bit product back out as four bytes.
module mult_byte_frontend #(
    parameter int OP_W        = 16,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_byte_frontend_if.slave  bus,
    output logic                 mul_start,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [RES_W-1:0]     mul_c,
    input  logic                 mul_calculated
);
    import mult_pkg::*;

    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);

    fe_state_t           state;
    logic [1:0]          byte_idx;
    logic [2*OP_W-1:0]   opnd;
    logic [RES_W-1:0]    res;
    logic [7:0]          tcnt;
    logic                wr_fire;
    logic                rd_fire;

    assign bus.wr_ready = (state == LOAD);
    assign bus.rd_valid = (state == SEND);
    assign bus.rd_data  = (state == SEND) ? byte_sel(res, byte_idx) : 8'h00;

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            byte_idx  <= 2'd0;
            opnd      <= '0;
            res       <= '0;
            tcnt      <= 8'd0;
            bus.err   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_fire) begin
                        opnd[{byte_idx, 3'b000} +: 8] <= bus.wr_data;
                        byte_idx <= byte_idx + 2'd1;
                        bus.err  <= 1'b0;
                        if (byte_idx == 2'd3)
                            state <= ARM;
                    end
                end
                // Start stays low through this cycle so the multiplier restarts its counter.
                ARM: begin
                    mul_a     <= opnd[OP_W-1:0];
                    mul_b     <= opnd[2*OP_W-1:OP_W];
                    tcnt      <= 8'd0;
                    mul_start <= 1'b1;
                    state     <= RUN;
                end
                // tcnt==0 marks the first RUN cycle, where a stale sticky flag is ignored.
                RUN: begin
                    if (tcnt != 8'd0 && mul_calculated) begin
                        res       <= mul_c;
                        bus.err   <= 1'b0;
                        mul_start <= 1'b0;
                        state     <= SEND;
                    end else if (tcnt == TLAST) begin
                        res       <= RES_W'(TIMEOUT_RESULT);
                        bus.err   <= 1'b1;
                        mul_start <= 1'b0;
                        state     <= SEND;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                SEND: begin
                    if (rd_fire) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_byte_frontend.sv
// Self-checking bench for mult_byte_frontend driving a behavioural shift-add multiplier.
module tb_mult_byte_frontend;

    localparam int TO  = 64;
    localparam int LAT = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_c;
    logic        mul_calculated;

    int          checks = 0;
    int          failures = 0;
    int          mode = 0;          // 0 real multiplier, 1 never completes, 2 forced product
    logic [31:0] forced_c = 32'h0;
    int          mcnt;
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    mult_byte_frontend_if bus();

    mult_byte_frontend #(.OP_W(16), .RES_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c(mul_c), .mul_calculated(mul_calculated)
    );

    // Downstream multiplier: restarts while start is low, flag is sticky until the next run begins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0;
            mul_calculated <= 1'b0;
            mul_c <= 32'h0;
        end else if (!mul_start) begin
            mcnt <= 0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == 0)
                mul_calculated <= 1'b0;
            else if (mcnt == LAT - 1 && mode != 1) begin
                mul_calculated <= 1'b1;
                mul_c <= (mode == 2) ? forced_c : {16'h0, mul_a} * {16'h0, mul_b};
            end
        end
    end

    always @(posedge clk)
        if (bus.wr_valid && bus.wr_ready) acc_cnt <= acc_cnt + 1;

    function automatic logic [31:0] ref_prod(input logic [31:0] w);
        return {16'h0, w[15:0]} * {16'h0, w[31:16]};
    endfunction

    task automatic write_bytes(input logic [31:0] w, input int first, input int last, output bit ok);
        int n;
        ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = w[8*i +: 8];
            n = 0;
            while (!bus.wr_ready && n < 500) begin
                @(posedge clk); #1; n++;
            end
            if (!bus.wr_ready) ok = 1'b0;
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_word(input bit rnd, input int nb, output logic [31:0] w,
                             output logic e, output bit ok);
        int i;
        int n;
        i = 0; n = 0; w = 32'h0; e = 1'b0;
        while (i < nb && n < 600) begin
            bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rd_valid && bus.rd_ready) begin
                w[8*i +: 8] = bus.rd_data;
                e = bus.err;
                i++;
            end
            @(posedge clk); #1; n++;
        end
        bus.rd_ready = 1'b0;
        ok = (i == nb);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if ({mul_start, mul_a, mul_b} !== 33'h0) begin failures++; $display("FAIL reset_mul got=%b/%h/%h exp=0/0000/0000", mul_start, mul_a, mul_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] w, r; logic e; bit ok;
        w = 32'h0005_0003;
        write_bytes(w, 0, 3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_write_timeout got=0 exp=1"); end
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL basic_arm_start got=%b exp=0", mul_start); end
        @(posedge clk); #1;
        checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL basic_run_start got=%b exp=1", mul_start); end
        checks++; if (mul_a !== w[15:0] || mul_b !== w[31:16]) begin failures++; $display("FAIL basic_operands got=%h/%h exp=%h/%h", mul_a, mul_b, w[15:0], w[31:16]); end
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== ref_prod(w)) begin failures++; $display("FAIL basic_result got=%h exp=%h", r, ref_prod(w)); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", e); end
    endtask

    task automatic test_sticky();
        logic [31:0] w, r; logic e; bit ok;
        w = 32'hFFFF_FFFF;
        write_bytes(w, 0, 3, ok);
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== 32'hFFFE_0001) begin failures++; $display("FAIL sticky_max got=%h exp=fffe0001", r); end
        w = 32'h0004_0002;
        write_bytes(w, 0, 3, ok);
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== 32'h0000_0008) begin failures++; $display("FAIL sticky_second got=%h exp=00000008", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL sticky_err got=%b exp=0", e); end
    endtask

    task automatic test_stall();
        logic [31:0] r; logic e; bit ok; int n;
        mode = 2; forced_c = 32'h1234_5678;
        write_bytes($urandom, 0, 3, ok);
        n = 0;
        while (!bus.rd_valid && n < 500) begin @(posedge clk); #1; n++; end
        checks++; if (bus.rd_data !== forced_c[7:0]) begin failures++; $display("FAIL stall_byte0 got=%h exp=%h", bus.rd_data, forced_c[7:0]); end
        bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== forced_c[15:8] || bus.wr_ready !== 1'b0) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/0", k, bus.rd_valid, bus.rd_data, bus.wr_ready, forced_c[15:8]);
            end
            @(posedge clk); #1;
        end
        read_word(1'b0, 2, r, e, ok);
        checks++; if (!ok || r[15:0] !== forced_c[23:8]) begin failures++; $display("FAIL stall_tail got=%h exp=%h", r[15:0], forced_c[23:8]); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL stall_wr_ready_before_last got=%b exp=0", bus.wr_ready); end
        read_word(1'b0, 1, r, e, ok);
        checks++; if (!ok || r[7:0] !== forced_c[31:24]) begin failures++; $display("FAIL stall_last got=%h exp=%h", r[7:0], forced_c[31:24]); end
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL stall_wr_ready_after got=%b exp=1", bus.wr_ready); end
        mode = 0;
    endtask

    task automatic test_timeout();
        logic [31:0] w, r; logic e; bit ok; int n;
        mode = 1;
        write_bytes($urandom, 0, 3, ok);
        n = 0;
        while (!mul_start && n < 50) begin @(posedge clk); #1; n++; end
        n = 0;
        while (mul_start && n < 1000) begin n++; @(posedge clk); #1; end
        checks++; if (n !== TO) begin failures++; $display("FAIL timeout_run_cycles got=%0d exp=%0d", n, TO); end
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timeout_result got=%h exp=ffffffff", r); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", e); end
        mode = 0;
        w = {$urandom};
        bus.wr_valid = 1'b1; bus.wr_data = w[7:0];
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL timeout_err_held got=%b exp=1", bus.err); end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear got=%b exp=0", bus.err); end
        write_bytes(w, 1, 3, ok);
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== ref_prod(w) || e !== 1'b0) begin failures++; $display("FAIL timeout_recover got=%h/%b exp=%h/0", r, e, ref_prod(w)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, r; logic e; bit ok; int n; int seen;
        write_bytes(32'h0007_0009, 0, 3, ok);
        n = 0;
        while (!mul_start && n < 50) begin @(posedge clk); #1; n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mul_start !== 1'b0 || mul_a !== 16'h0 || bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
            failures++; $display("FAIL rst_run got=%b/%h/%b/%b exp=0/0000/1/0", mul_start, mul_a, bus.wr_ready, bus.rd_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.rd_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_no_partial got=%0d exp=0", seen); end
        write_bytes(32'h0003_0011, 0, 3, ok);
        read_word(1'b0, 2, r, e, ok);
        checks++; if (!ok || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL rst_send_reach got=%b exp=1", bus.rd_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.err !== 1'b0) begin
            failures++; $display("FAIL rst_send got=%b/%h/%b exp=0/00/0", bus.rd_valid, bus.rd_data, bus.err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        w = 32'h000A_000A;
        write_bytes(w, 0, 3, ok);
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== 32'h0000_0064) begin failures++; $display("FAIL rst_clean_op got=%h exp=00000064", r); end
    endtask

    task automatic test_continuous();
        logic [31:0] w1, w2, r; logic e; bit ok; int acc0;
        w1 = $urandom; w2 = $urandom;
        acc0 = acc_cnt;
        write_bytes(w1, 0, 3, ok);
        bus.wr_valid = 1'b1; bus.wr_data = w2[7:0];
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== ref_prod(w1)) begin failures++; $display("FAIL cont_op1 got=%h exp=%h", r, ref_prod(w1)); end
        checks++; if (acc_cnt - acc0 !== 4) begin failures++; $display("FAIL cont_accept_busy got=%0d exp=4", acc_cnt - acc0); end
        write_bytes(w2, 0, 3, ok);
        read_word(1'b0, 4, r, e, ok);
        checks++; if (!ok || r !== ref_prod(w2)) begin failures++; $display("FAIL cont_op2 got=%h exp=%h", r, ref_prod(w2)); end
        checks++; if (acc_cnt - acc0 !== 8) begin failures++; $display("FAIL cont_accept_total got=%0d exp=8", acc_cnt - acc0); end
    endtask

    task automatic test_random();
        logic [31:0] w, r; logic e; bit ok;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            if (k == 0) w = 32'h0000_FFFF;
            write_bytes(w, 0, 3, ok);
            read_word(1'b1, 4, r, e, ok);
            checks++; if (!ok || r !== ref_prod(w) || e !== 1'b0) begin
                failures++; $display("FAIL random_op k=%0d a=%h b=%h got=%h/%b exp=%h/0", k, w[15:0], w[31:16], r, e, ref_prod(w));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_sticky();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_continuous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_byte_frontend.md
Name: mult_byte_frontend

Overview:
- Byte-serial front end placed directly upstream of the 16x16 shift-add multiplier. It also collects that multiplier's result.
- Assembles two 16-bit operands from an 8-bit write stream, drives the multiplier's start/a/b and holds them stable, then captures the 32-bit product.
- Returns the product as four bytes on an 8-bit valid/ready read stream, with a timeout guard against a stalled multiplier.

Parameters:
- OP_W, 16, operand width; fixed at 16 for this multiplier.
- RES_W, 32, product width; fixed at 2*OP_W.
- TIMEOUT_CYC, 64, number of cycles to wait for mul_calculated before aborting; legal range 8..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write byte valid
- wr_ready  out  1  front end accepts write byte
- wr_data  in  8  operand byte; order is a[7:0], a[15:8], b[7:0], b[15:8]
- rd_valid  out  1  result byte valid
- rd_ready  in  1  consumer accepts result byte
- rd_data  out  8  result byte; order is c[7:0], c[15:8], c[23:16], c[31:24]
- err  out  1  timeout flag for the current result
- mul_start  out  1  to multiplier start, held high for the whole computation
- mul_a  out  16  to multiplier a
- mul_b  out  16  to multiplier b
- mul_c  in  32  from multiplier c
- mul_calculated  in  1  from multiplier; valid-high, may remain high (sticky)

Behaviour:
- Reset, asynchronous, when rst_n=0:
  - state=LOAD, byte_idx=0, wr_ready=1, rd_valid=0, rd_data=0, err=0.
  - mul_start=0, mul_a=0, mul_b=0, result register=0, timeout counter=0.
- Reset mid-operation aborts immediately. No partial result is ever presented after reset.
- A handshake fires on a cycle where valid & ready are both 1.
- State LOAD:
  - wr_ready=1. Each fired write stores wr_data into the operand byte selected by byte_idx, then byte_idx increments.
  - On the 4th byte (byte_idx=3), the next cycle enters ARM. byte_idx wraps to 0.
- State ARM (1 cycle):
  - wr_ready=0. mul_a and mul_b are registered from the assembled operands. mul_start=0. Timeout counter is cleared.
  - Purpose: the multiplier sees start low for at least one cycle, which restarts its internal counter.
- State RUN:
  - mul_start=1. mul_a and mul_b are held constant. The timeout counter increments each cycle.
  - mul_calculated is ignored on the first RUN cycle, because a sticky flag from the previous operation may still be high.
  - From the 2nd RUN cycle on, the first cycle with mul_calculated=1 captures mul_c into the result register, sets err=0, and goes to SEND.
  - When the counter reaches TIMEOUT_CYC-1 without a capture: result register=32'hFFFF_FFFF, err=1, go to SEND.
  - If capture and the timeout occur in the same cycle, the capture wins.
- State SEND:
  - mul_start=0. rd_valid=1 and rd_data=result byte[byte_idx].
  - On each fired read, byte_idx increments. rd_data is stable while rd_valid=1 and rd_ready=0.
  - After the 4th fired read, rd_valid=0, byte_idx=0, go to LOAD.
  - err holds its value until the first write byte of the next operation is accepted.
- wr_ready=0 in ARM, RUN and SEND. Writes offered there are not accepted and are not lost; the source holds them.
- Latency:
  - Last write byte to mul_start rising: 2 cycles (LOAD->ARM->RUN).
  - mul_calculated capture to rd_valid: 1 cycle.
- No arithmetic is done here. Byte packing is little-endian; widths are exact with no sign extension.

Decomposition:
- Shared package mult_pkg holds:
  - typedef enum logic[1:0] {LOAD, ARM, RUN, SEND} fe_state_t.
  - localparams OP_W=16, RES_W=32, NBYTES_OP=4, NBYTES_RES=4.
  - TIMEOUT_RESULT=32'hFFFF_FFFF.
- No sub-module. The FSM, the byte packer/unpacker and the timeout counter stay in one module. The byte index counter is shared between LOAD and SEND.
- The bench instantiates the existing multiplier as the DUT's downstream, plus a stub multiplier model for the timeout cases.

Test Plan:
- Write 03,00,05,00 with the real multiplier and rd_ready=1 → mul_a=0003, mul_b=0005, mul_start high from LOAD+2; read bytes 0F,00,00,00; err=0.
- Write FF,FF,FF,FF → read 01,00,FE,FF (FFFE0001); a second op 02,00,04,00 → 08,00,00,00, which proves the sticky mul_calculated is not captured early.
- Hold rd_ready=0 for 5 cycles mid-SEND, after byte 1 of product 12345678 → rd_data stays 56 with rd_valid=1; then 34, 12 follow; wr_ready=0 until the last byte fires.
- Stub multiplier that never asserts mul_calculated → after TIMEOUT_CYC cycles in RUN, read FF,FF,FF,FF with err=1; err clears on the next accepted write byte.
- Assert rst_n=0 during RUN and during SEND byte 2 → outputs take reset values asynchronously; after release, a clean op 0A,00,0A,00 → 64,00,00,00.
- Offer wr_valid=1 continuously through ARM/RUN/SEND → exactly 4 bytes are accepted per operation; no byte is consumed outside LOAD.
